// File: rtl/l_class_oc_fifo_n.sv
// l_class_oc_fifo_n: registered-ready circular FIFO with flush and almost-full flag
module l_class_oc_fifo_n #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_enq__ENA,
  input  logic [WIDTH-1:0]       in_enq_v,
  output logic                   in_enq__RDY,
  input  logic                   out_deq__ENA,
  output logic                   out_deq__RDY,
  output logic [WIDTH-1:0]       out_first,
  output logic                   out_first__RDY,
  input  logic                   clear__ENA,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic enq, deq, flush;
  assign in_enq__RDY    = count_q != CW'(DEPTH);
  assign out_deq__RDY   = count_q != '0;
  assign out_first__RDY = out_deq__RDY;
  assign out_first      = mem[rptr_q];
  assign count          = count_q;
  assign almost_full    = count_q >= CW'(AFULL_LEVEL);
  assign enq   = in_enq__ENA && in_enq__RDY;
  assign deq   = out_deq__ENA && out_deq__RDY;
  assign flush = RST || clear__ENA;
  always_comb begin
    rptr_d  = flush ? '0 : rptr_q + AW'(deq);
    wptr_d  = flush ? '0 : wptr_q + AW'(enq);
    count_d = flush ? '0 : count_q + CW'(enq) - CW'(deq);
  end
  always_ff @(posedge CLK) begin
    rptr_q  <= rptr_d;
    wptr_q  <= wptr_d;
    count_q <= count_d;
    if (enq && !flush) mem[wptr_q] <= in_enq_v;
  end
endmodule

// File: doc/l_class_oc_fifo_n.md
L_CLASS_OC_FIFO_N -- requirements
Module: l_class_oc_fifo_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data bits per entry.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the entry count; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter AFULL_LEVEL, default DEPTH-1, meaning the occupancy at or above which almost_full asserts; legal range is 1..DEPTH.
REQ-004 The block SHALL have one clock and a synchronous active-high reset: CLK and RST.
REQ-005 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 RST  input  1  synchronous reset, active-high.
REQ-007 in_enq__ENA  input  1  enqueue request.
REQ-008 in_enq_v  input  WIDTH  enqueue data.
REQ-009 in_enq__RDY  output  1  enqueue can be accepted.
REQ-010 out_deq__ENA  input  1  dequeue request.
REQ-011 out_deq__RDY  output  1  dequeue can be accepted.
REQ-012 out_first  output  WIDTH  head-of-queue data.
REQ-013 out_first__RDY  output  1  out_first is valid.
REQ-014 clear__ENA  input  1  flush request; always accepted.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 almost_full  output  1  count >= AFULL_LEVEL.

Function
REQ-017 Storage SHALL be a DEPTH x WIDTH array with read pointer rptr and write pointer wptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-018 in_enq__RDY SHALL equal (count != DEPTH); out_deq__RDY and out_first__RDY SHALL equal (count != 0).
REQ-019 All RDY outputs, count and almost_full SHALL be functions of registered state only, with no combinational path from any ENA input or in_enq_v.
REQ-020 Enqueue fires when in_enq__ENA && in_enq__RDY: mem[wptr] <= in_enq_v, wptr advances by 1.
REQ-021 Dequeue fires when out_deq__ENA && out_deq__RDY: rptr advances by 1.
REQ-022 An ENA asserted while its RDY is low SHALL be ignored, with no state change.
REQ-023 out_first SHALL equal mem[rptr]; its value while out_first__RDY is low is unspecified.
REQ-024 Latency: data enqueued on cycle N SHALL appear on out_first at N+1 if the queue was empty; there is no same-cycle bypass.
REQ-025 count SHALL be +1 on enqueue only, -1 on dequeue only, and unchanged on both or neither.
REQ-026 Simultaneous enqueue and dequeue with 0 < count < DEPTH SHALL both fire, advancing both pointers with count unchanged.
REQ-027 When empty, only an enqueue can fire; when full, only a dequeue can fire (no pass-through, no full-bypass).
REQ-028 Ordering SHALL be strict FIFO across pointer wrap-around.
REQ-029 clear__ENA SHALL take priority: count, rptr and wptr SHALL be 0 next cycle, and any enqueue or dequeue in the same cycle is discarded.
REQ-030 Storage contents SHALL NOT be altered by clear.

Reset
REQ-031 While RST is high at a CLK edge, count, rptr and wptr SHALL become 0, giving in_enq__RDY=1, out_deq__RDY=0, out_first__RDY=0 and almost_full=0.
REQ-032 Storage array SHALL NOT be reset.
REQ-033 RST SHALL override clear__ENA and all ENA inputs.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries within one cycle.

Verification
REQ-035 Reset: assert RST for 2 cycles -> count=0, in_enq__RDY=1, out_deq__RDY=0, almost_full=0.
REQ-036 Fill (DEPTH=4, AFULL_LEVEL=3): enqueue 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> almost_full=1 after the 3rd, count=4, in_enq__RDY=0; then a 5th enqueue of 0x55 is ignored with count still 4.
REQ-037 Drain: dequeue 4 times -> out_first reads 0x11, 0x22, 0x33, 0x44 in order, then out_first__RDY=0 and count=0.
REQ-038 Simultaneous: at count=2 (head 0xA0), assert enqueue 0xB0 and dequeue for 5 cycles -> count stays 2, pointers wrap past 3, and out_first follows FIFO order.
REQ-039 Boundaries: at count=0 assert enqueue 0x5 and dequeue together -> only the enqueue fires and count=1; at count=4 assert both -> only the dequeue fires and count=3.
REQ-040 Clear/reset mid-op: at count=3 assert clear__ENA with in_enq__ENA -> count=0 next cycle and the enqueued data is not visible; repeat with RST -> same result.
